// File: rtl/imem_loader.sv
// imem_loader: write-side companion to the instruction memory.
// Accepts a byte stream over a valid/ready handshake and writes it into
// consecutive instruction memory locations starting at address 0. The CPU
// is held in reset (cpu_hold=1) until a complete image has been loaded.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra checksum beat follows the data beats. The
//   (8-bit running sum + checksum) must be 0 mod 256, or the load fails.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, len          single-cycle load request, word count sampled on start
//   abort               cancels a load in progress
//   in_valid, in_data   host byte stream
//   in_ready            loader accepts in_data this cycle (decode of state)
//   mem_we/addr/wdata   instruction memory write port (registered)
//   busy, done, err     status; err is sticky until reset or a valid start
//   cpu_hold            holds CPU in reset while high
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic len_ok;
  logic beat;

  assign len_ok = (len != '0) && (len <= DEPTH_L);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    in_ready    = (state_q == LOAD) || (state_q == CHECK);
`else
    in_ready    = (state_q == LOAD);
`endif
    busy        = in_ready;
    done        = (state_q == DONE);
    cpu_hold    = ~done;
    beat        = in_valid && in_ready;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = len;
            count_d = '0;
            err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // abort takes priority: the beat presented alongside it is dropped
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          count_d     = count_q + ONE_L;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + 8'(in_data);
          if (count_d == len_q) state_d = CHECK;
`else
          if (count_d == len_q) state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (beat) begin
          // checksum beat is consumed but never written to memory
          if ((sum_q + 8'(in_data)) == 8'd0) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
